// File: rtl/mux_rr_nto1_pkg.sv
// Shared constants and helpers for the round-robin N:1 registered mux.
package mux_rr_nto1_pkg;

    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

    // Index of the channel `off` places after `base`, wrapped into 0..n-1.
    function automatic int wrap_add(int base, int off, int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/mux_rr_nto1_rr_arbiter.sv
// One-hot arbiter over the request vector; round-robin or fixed priority.
module rr_arbiter
    import mux_rr_nto1_pkg::*;
#(
    parameter int NUM_INPUTS = 4,
    parameter int FIXED_PRIO = ARB_RR,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [NUM_INPUTS-1:0] Req,
    input  logic                  Advance,
    output logic [NUM_INPUTS-1:0] Grant,
    output logic [SEL_WIDTH-1:0]  Grant_Idx
);

    logic [SEL_WIDTH-1:0] ptr;
    logic                 found;
    int                   base;

    always_comb begin
        Grant     = '0;
        Grant_Idx = '0;
        found     = 1'b0;
        base      = (FIXED_PRIO == ARB_FIXED) ? 0 : int'(ptr);
        for (int k = 0; k < NUM_INPUTS; k++) begin
            if (!found && Req[wrap_add(base, k, NUM_INPUTS)]) begin
                found = 1'b1;
                Grant[wrap_add(base, k, NUM_INPUTS)] = 1'b1;
                Grant_Idx = SEL_WIDTH'(wrap_add(base, k, NUM_INPUTS));
            end
        end
    end

    // Pointer moves past the winner only on a real transfer.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr <= '0;
        end else if (FIXED_PRIO != ARB_FIXED && Advance) begin
            if (int'(Grant_Idx) == NUM_INPUTS - 1)
                ptr <= '0;
            else
                ptr <= Grant_Idx + SEL_WIDTH'(1);
        end
    end

endmodule

// File: rtl/mux_rr_nto1.sv
// N:1 arbitrated mux with valid/ready on every side and one output register.
module mux_rr_nto1
    import mux_rr_nto1_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_INPUTS = 4,
    parameter int SEL_WIDTH  = $clog2(NUM_INPUTS),
    parameter int FIXED_PRIO = ARB_RR
) (
    input  logic                             Clk,
    input  logic                             Reset,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] In_Data,
    input  logic [NUM_INPUTS-1:0]            In_Valid,
    output logic [NUM_INPUTS-1:0]            In_Ready,
    output logic [DATA_WIDTH-1:0]            Out_Data,
    output logic [SEL_WIDTH-1:0]             Out_Sel,
    output logic                             Out_Valid,
    input  logic                             Out_Ready
);

    logic                  load;
    logic                  xfer;
    logic [NUM_INPUTS-1:0] grant;
    logic [SEL_WIDTH-1:0]  grant_idx;

    rr_arbiter #(
        .NUM_INPUTS (NUM_INPUTS),
        .FIXED_PRIO (FIXED_PRIO),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_arb (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req       (In_Valid),
        .Advance   (xfer),
        .Grant     (grant),
        .Grant_Idx (grant_idx)
    );

    assign load     = !Out_Valid || Out_Ready;
    // Ready is forced low during reset so nothing is acked while state clears.
    assign In_Ready = (Reset || !load) ? '0 : grant;
    assign xfer     = |(In_Valid & In_Ready);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Out_Valid <= 1'b0;
            Out_Data  <= '0;
            Out_Sel   <= '0;
        end else if (load) begin
            Out_Valid <= xfer;
            if (xfer) begin
                Out_Data <= In_Data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
                Out_Sel  <= grant_idx;
            end
        end
    end

endmodule
